seq_scan_arbiter: RTL

//  Shares one serial "010" pattern detector among NREQ requesters.

---
 rtl/seq_scan_pkg.sv | 18 +
 rtl/pattern_detect_010.sv | 37 +++
 rtl/seq_scan_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/seq_scan_pkg.sv
// Shared types and defaults for the sequential "010" scan arbiter.
// The det_state_t encodings are fixed: NOTHING=00, SAW0=01, SAW1=10.
package seq_scan_pkg;
  localparam int NREQ_DEF  = 4;
  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_REPORT = 2'd2
  } scan_state_t;

  typedef enum logic [1:0] {
    NOTHING = 2'b00,
    SAW0    = 2'b01,
    SAW1    = 2'b10
  } det_state_t;
endpackage

// File: rtl/pattern_detect_010.sv
// Bit-serial overlapping "010" detector; match is combinational (Mealy) on the current bit.
// clear forces NOTHING, en=0 holds the state.
module pattern_detect_010 (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_en,
  input  logic i_a,
  output logic o_match
);
  import seq_scan_pkg::*;

  det_state_t r_state;
  det_state_t w_next;

  always_ff @(posedge i_clock) begin
    if (i_reset || i_clear) begin
      r_state <= NOTHING;
    end else if (i_en) begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    o_match = 1'b0;
    case (r_state)
      NOTHING: w_next = i_a ? NOTHING : SAW0;
      SAW0:    w_next = i_a ? SAW1 : SAW0;
      SAW1: begin
        w_next  = i_a ? NOTHING : SAW0;
        o_match = ~i_a;
      end
      default: w_next = NOTHING;
    endcase
  end
endmodule

// File: rtl/seq_scan_arbiter.sv
// Round-robin arbiter feeding one latched word MSB-first into a shared "010" detector; done WIDTH edges after grant.
// Requests wait while busy (held req is never lost); SEQ_SCAN_ABORT_EN adds i_abort/o_aborted for early termination.
module seq_scan_arbiter
  import seq_scan_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int WIDTH = WIDTH_DEF,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [NREQ-1:0]       i_req,
  input  logic [NREQ*WIDTH-1:0] i_data,
`ifdef SEQ_SCAN_ABORT_EN
  input  logic                  i_abort,
  output logic                  o_aborted,
`endif
  output logic [NREQ-1:0]       o_gnt,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [CNT_W-1:0]      o_count
);
  localparam int PTR_W = $clog2(NREQ);

  scan_state_t      r_state;
  scan_state_t      w_state_nxt;
  logic [PTR_W-1:0] r_ptr;
  logic [WIDTH-1:0] r_shreg;
  logic [CNT_W-1:0] r_bitcnt;
  logic [CNT_W-1:0] r_count;
  logic [NREQ-1:0]  r_gnt;

  logic             w_start;
  logic             w_shift_en;
  logic             w_abort;
  logic             w_match;
  logic             w_found;
  int               w_idx;
  logic [PTR_W-1:0] w_win;
  logic [WIDTH-1:0] w_win_word;

  // Search starts one past the last winner, wrapping at NREQ.
  always_comb begin
    w_found = 1'b0;
    w_idx   = 0;
    w_win   = r_ptr;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = int'(r_ptr) + k;
      if (w_idx >= NREQ) w_idx = w_idx - NREQ;
      if (!w_found && i_req[w_idx]) begin
        w_found = 1'b1;
        w_win   = PTR_W'(w_idx);
      end
    end
    w_win_word = i_data[w_win*WIDTH +: WIDTH];
  end

  assign w_start = (r_state == S_IDLE) && (|i_req);

`ifdef SEQ_SCAN_ABORT_EN
  assign w_abort = (r_state == S_SHIFT) && i_abort;
`else
  assign w_abort = 1'b0;
`endif

  assign w_shift_en = (r_state == S_SHIFT) && !w_abort;

  pattern_detect_010 u_det (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_clear (w_start),
    .i_en    (w_shift_en),
    .i_a     (r_shreg[WIDTH-1]),
    .o_match (w_match)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (|i_req) w_state_nxt = S_SHIFT;
      S_SHIFT:  if (w_abort || (r_bitcnt == CNT_W'(WIDTH - 1))) w_state_nxt = S_REPORT;
      S_REPORT: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state  <= S_IDLE;
      r_ptr    <= PTR_W'(NREQ - 1);
      r_shreg  <= '0;
      r_bitcnt <= '0;
      r_count  <= '0;
      r_gnt    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_gnt    <= {{(NREQ-1){1'b0}}, 1'b1} << w_win;
        r_ptr    <= w_win;
        r_shreg  <= w_win_word;
        r_bitcnt <= '0;
        r_count  <= '0;
      end else if (w_shift_en) begin
        r_shreg  <= {r_shreg[WIDTH-2:0], 1'b0};
        r_bitcnt <= r_bitcnt + CNT_W'(1);
        if (w_match) r_count <= r_count + CNT_W'(1);
      end
      if (r_state == S_REPORT) r_gnt <= '0;
    end
  end

`ifdef SEQ_SCAN_ABORT_EN
  logic r_aborted;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_aborted <= 1'b0;
    end else if (w_abort) begin
      r_aborted <= 1'b1;
    end else if (r_state == S_REPORT) begin
      r_aborted <= 1'b0;
    end
  end

  assign o_aborted = r_aborted;
`endif

  assign o_gnt   = r_gnt;
  assign o_busy  = (r_state != S_IDLE);
  assign o_done  = (r_state == S_REPORT);
  assign o_count = r_count;
endmodule
